// File: rtl/obi_sram_device.sv
// Purpose: OBI data-memory responder with byte-enabled 64-bit writes and 64-bit reads.
// Latency: rvalid_o is raised LATENCY cycles after the grant edge. Responses come back in accept order.
// Backpressure: gnt_o drops once MAX_OUTSTANDING responses are pending. The response side cannot be stalled.
//
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low reset
//   req_i / gnt_o        request valid and combinational grant
//   addr_i, we_i,        byte address (word index = addr_i[63:3]), write enable,
//   be_i, wdata_i        byte enables and write data
//   gnt_block_i          forces gnt_o low; tie to 0 outside simulation
//   rvalid_o, rdata_o,   one-cycle response pulse, read data (0 for writes),
//   err_o                and out-of-range error flag
module obi_sram_device #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] wdata_i,
    input  logic        gnt_block_i,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [63:0]        mem [DEPTH_WORDS];
    logic [CW-1:0]      out_cnt;
    logic [LATENCY-1:0] pipe_vld;
    logic [LATENCY-1:0] pipe_err;
    logic [63:0]        pipe_dat [LATENCY];

    logic [60:0]        word_addr;
    logic [IW-1:0]      word_idx;
    logic               in_range;
    logic               accept;
    logic [63:0]        rd_word;
    logic               unused_addr_lsbs;

    assign word_addr = addr_i[63:3];
    // Compare against the full 61-bit word address so that high addresses
    // never alias onto low words.
    assign in_range  = (word_addr < 61'(DEPTH_WORDS));
    assign word_idx  = word_addr[IW-1:0];
    assign unused_addr_lsbs = ^addr_i[2:0];

    assign gnt_o  = rst_ni && req_i && !gnt_block_i && (out_cnt < CW'(MAX_OUTSTANDING));
    assign accept = req_i && gnt_o;

    // Array: no reset, so it can map onto plain memory.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < 8; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Read sampled at the accept edge. Writes land on the same edge through
    // non-blocking updates, so only earlier writes are visible.
    assign rd_word = mem[word_idx];

    // Response shift pipeline. Stage 0 is loaded on the accept edge, and every stage advances each cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_err[0] <= accept && !in_range;
            pipe_dat[0] <= (accept && !we_i && in_range) ? rd_word : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign rvalid_o = pipe_vld[LATENCY-1];
    assign err_o    = pipe_err[LATENCY-1];
    assign rdata_o  = pipe_dat[LATENCY-1];

    // Outstanding count. A response retiring on the same edge as a new accept
    // leaves the count unchanged. The freed slot is only granted on the next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt <= '0;
        end else if (accept && !rvalid_o) begin
            out_cnt <= out_cnt + CW'(1);
        end else if (!accept && rvalid_o) begin
            out_cnt <= out_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (out_cnt <= CW'(MAX_OUTSTANDING));
            assert (!(accept && !rvalid_o && (out_cnt == CW'(MAX_OUTSTANDING))));
            assert (!(rvalid_o && !accept && (out_cnt == '0)));
        end
    end

endmodule

// File: tb/tb_obi_sram_device.sv
// Directed bench: three responders sharing one request bus, each held in reset outside its own phase.
// u_a: LATENCY=1/MAX=2 (reset, byte enables, RAW, range). u_b: LATENCY=4/MAX=2 (limit). u_c: LATENCY=3 (mid-flight reset).
module tb_obi_sram_device;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        req, we, gblk;
    logic [63:0] addr, wdata;
    logic [7:0]  be;

    logic        gnt_a, rvalid_a, err_a;
    logic        gnt_b, rvalid_b, err_b;
    logic        gnt_c, rvalid_c, err_c;
    logic [63:0] rdata_a, rdata_b, rdata_c;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B1 = 64'h0B0B_0000_0000_00B1;
    localparam logic [63:0] B2 = 64'h0B0B_0000_0000_00B2;

    always #5 clk = ~clk;

    obi_sram_device #(.DEPTH_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
        .clk_i(clk), .rst_ni(rst_a), .req_i(req), .gnt_o(gnt_a), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_block_i(gblk),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a));

    obi_sram_device #(.DEPTH_WORDS(1024), .LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
        .clk_i(clk), .rst_ni(rst_b), .req_i(req), .gnt_o(gnt_b), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_block_i(gblk),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b));

    obi_sram_device #(.DEPTH_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(2)) u_c (
        .clk_i(clk), .rst_ni(rst_c), .req_i(req), .gnt_o(gnt_c), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_block_i(gblk),
        .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic r, input logic w, input logic [63:0] a,
                         input logic [7:0] b, input logic [63:0] d);
        req = r; we = w; addr = a; be = b; wdata = d;
        #1;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] d);
        edge1();
        apply(r, w, a, b, d);
    endtask

    initial begin
        logic [5:0]  b_gnt_exp;
        logic [5:0]  b_rv_exp;
        logic [63:0] b_rd_exp [6];

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; gblk = 1'b0;
        apply(1'b1, 1'b1, 64'h0, 8'hFF, W0);

        // Reset held with req_i high
        for (int i = 0; i < 3; i++) begin
            edge1();
            #1;
            chk("rst_gnt", gnt_a, 0);
            chk("rst_rvalid", rvalid_a, 0);
            chk("rst_rdata", rdata_a, 0);
            chk("rst_err", err_a, 0);
        end
        edge1();
        rst_a = 1'b1;
        #1;
        chk("rst_first_gnt", gnt_a, 1);
        chk("rst_first_rvalid", rvalid_a, 0);

        // Byte-enable write / readback (write of W0 to word 0 accepted here)
        cyc(1'b1, 1'b1, 64'h10, 8'hFF, 64'h1122_3344_5566_7788);
        chk("w0_rvalid", rvalid_a, 1);
        chk("w0_rdata", rdata_a, 0);
        chk("w0_err", err_a, 0);
        chk("w0_gnt", gnt_a, 1);
        cyc(1'b1, 1'b1, 64'h10, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("wfull_rvalid", rvalid_a, 1);
        cyc(1'b1, 1'b0, 64'h10, 8'h00, 64'h0);
        chk("wbe_rvalid", rvalid_a, 1);
        chk("wbe_rdata", rdata_a, 0);
        cyc(1'b1, 1'b0, 64'h13, 8'h00, 64'h0);
        chk("rd10_rvalid", rvalid_a, 1);
        chk("rd10_rdata", rdata_a, 64'h1122_3344_AAAA_AAAA);
        chk("rd10_err", err_a, 0);

        // Back-to-back RAW on 0x40
        cyc(1'b1, 1'b1, 64'h40, 8'hFF, 64'hDEAD_BEEF_0000_0000);
        chk("rd13_rdata", rdata_a, 64'h1122_3344_AAAA_AAAA);
        chk("raw_w_gnt", gnt_a, 1);
        cyc(1'b1, 1'b0, 64'h40, 8'h00, 64'h0);
        chk("raw_r_gnt", gnt_a, 1);
        chk("raw_w_rvalid", rvalid_a, 1);
        chk("raw_w_rdata", rdata_a, 0);

        // Out of range read and write
        cyc(1'b1, 1'b0, 64'h2000, 8'h00, 64'h0);
        chk("raw_r_gnt2", gnt_a, 1);
        chk("raw_r_rvalid", rvalid_a, 1);
        chk("raw_r_rdata", rdata_a, 64'hDEAD_BEEF_0000_0000);
        chk("raw_r_err", err_a, 0);
        cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("oor_rd_rvalid", rvalid_a, 1);
        chk("oor_rd_err", err_a, 1);
        chk("oor_rd_rdata", rdata_a, 0);
        cyc(1'b1, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("oor_wr_rvalid", rvalid_a, 1);
        chk("oor_wr_err", err_a, 1);
        chk("oor_wr_rdata", rdata_a, 0);
        cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("word0_rvalid", rvalid_a, 1);
        chk("word0_rdata", rdata_a, W0);
        chk("word0_err", err_a, 0);

        // Grant blocking hook
        edge1();
        gblk = 1'b1;
        apply(1'b1, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("blk_gnt", gnt_a, 0);
        chk("idle_rvalid", rvalid_a, 0);
        chk("idle_rdata", rdata_a, 0);

        // Outstanding limit: LATENCY=4, MAX_OUTSTANDING=2
        edge1();
        gblk = 1'b0; rst_a = 1'b0; rst_b = 1'b1;
        apply(1'b1, 1'b1, 64'h08, 8'hFF, B1);
        chk("b_w1_gnt", gnt_b, 1);
        cyc(1'b1, 1'b1, 64'h10, 8'hFF, B2);
        chk("b_w2_gnt", gnt_b, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
            chk("b_wr_rvalid", rvalid_b, (i == 2 || i == 3) ? 64'd1 : 64'd0);
        end

        b_gnt_exp = 6'b100011;
        b_rv_exp  = 6'b110000;
        b_rd_exp  = '{64'h0, 64'h0, 64'h0, 64'h0, B1, B2};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, (i == 1) ? 64'h10 : 64'h08, 8'h00, 64'h0);
            chk("b_gnt_pattern", gnt_b, b_gnt_exp[i]);
            chk("b_rvalid", rvalid_b, b_rv_exp[i]);
            chk("b_rdata_order", rdata_b, b_rd_exp[i]);
            chk("b_err", err_b, 0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
            chk("b_tail_rvalid", rvalid_b, (i == 3) ? 64'd1 : 64'd0);
            chk("b_tail_rdata", rdata_b, (i == 3) ? B1 : 64'd0);
        end

        // Reset mid-flight: LATENCY=3
        edge1();
        rst_b = 1'b0; rst_c = 1'b1;
        apply(1'b1, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("c_gnt0", gnt_c, 1);
        cyc(1'b1, 1'b0, 64'h08, 8'h00, 64'h0);
        chk("c_gnt1", gnt_c, 1);
        edge1();
        rst_c = 1'b0;
        apply(1'b1, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("c_rst_gnt", gnt_c, 0);
        chk("c_rst_rvalid", rvalid_c, 0);
        edge1();
        rst_c = 1'b1;
        apply(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("c_rel_rvalid", rvalid_c, 0);
        chk("c_rel_outstanding", u_c.out_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
            chk("c_no_rvalid", rvalid_c, 0);
            chk("c_no_rdata", rdata_c, 0);
            chk("c_no_err", err_c, 0);
        end
        cyc(1'b1, 1'b0, 64'h0, 8'h00, 64'h0);
        chk("c_regrant", gnt_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
